// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, the NOP encoding,
// the fetch FSM state type and the default reset PC.
package riscv_pkg;

    // Major opcodes (instr[6:0]) decoded by the control unit
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0 -- harmless filler while no real instruction is held
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // Address of the first instruction fetched after reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch sequencing: one request, wait for data, present it, repeat
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC generator: sequential pc+4 (wrapping modulo 2^32) or a word-aligned
// branch redirect. The misalignment flag exists only when
// IFETCH_MISALIGN_CHK_EN is defined; otherwise it is a constant 0.
module fetch_pc_gen
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        misalign
);

    // Redirect targets drop their low two bits; sequential path wraps naturally
    always_comb begin
        next_pc = pc + 32'd4;
        if (branch_taken) begin
            next_pc = {branch_target[31:2], 2'b00};
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    assign misalign = branch_taken && (branch_target[1:0] != 2'b00);
`else
    // Low target bits only matter to the check; keep them visibly unused
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^branch_target[1:0];
    assign misalign       = 1'b0;
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one read at a time to instruction memory,
// holds the returned word until downstream consumes it, then advances the PC
// sequentially or to a resolved branch target.
// Optional feature macro: IFETCH_MISALIGN_CHK_EN (misaligned-target pulse).
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode,
    output logic        misalign_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         imem_req_q, imem_req_d;
    logic         instr_valid_q, instr_valid_d;

    logic [31:0]  next_pc;
    logic         misalign_raw;
    logic         consume;

    fetch_pc_gen u_pc_gen (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .misalign      (misalign_raw)
    );

    // Instruction leaves the stage only when held and downstream is not stalled
    assign consume = (state_q == S_HOLD) && !stall;

    // Next-state and datapath updates; outputs are decoded from the next state
    // so they come out of flops aligned with the state they describe
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                // Only this state listens to rvalid, so at most one request
                // is ever in flight and stray responses are dropped
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                // A stalled instruction is not resolved, so branch is ignored
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_RESET;
        endcase
        imem_req_d    = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_HOLD);
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misalign_err_q, misalign_err_d;

    // Pulse in the cycle following a misaligned redirect
    assign misalign_err_d = consume && misalign_raw;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_raw ^ consume;
`endif

    // Fetch FSM state, PC, held instruction and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_RESET;
            pc_q           <= RESET_PC;
            instr_q        <= INSTR_NOP;
            instr_pc_q     <= 32'h0000_0000;
            imem_req_q     <= 1'b0;
            instr_valid_q  <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_err_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            imem_req_q     <= imem_req_d;
            instr_valid_q  <= instr_valid_d;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_err_q <= misalign_err_d;
`endif
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign opcode      = instr_q[6:0];

`ifdef IFETCH_MISALIGN_CHK_EN
    assign misalign_err = misalign_err_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: imem_req  output  1  one-cycle read request to instruction memory.
REQ-005 SHALL have port: imem_addr  output  32  word address of the request, valid while imem_req=1.
REQ-006 SHALL have port: imem_rvalid  input  1  read data valid, any cycle after the request.
REQ-007 SHALL have port: imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-008 SHALL have port: stall  input  1  downstream hold; the current instruction is not consumed.
REQ-009 SHALL have port: branch_taken  input  1  resolved branch for the currently valid instruction.
REQ-010 SHALL have port: branch_target  input  32  redirect address, used when branch_taken=1.
REQ-011 SHALL have port: instr_valid  output  1  instr, instr_pc and opcode are valid.
REQ-012 SHALL have port: instr  output  32  registered fetched instruction.
REQ-013 SHALL have port: instr_pc  output  32  address of instr.
REQ-014 SHALL have port: opcode  output  7  instr[6:0], feeds control_unit.
REQ-015 SHALL have port: misalign_err  output  1  one-cycle pulse on a misaligned branch target.

Function
REQ-016 SHALL implement FSM states S_RESET, S_FETCH, S_WAIT, S_HOLD; S_RESET->S_FETCH unconditionally after one cycle.
REQ-017 In S_FETCH SHALL drive imem_req=1, imem_addr=pc, then go to S_WAIT; imem_req=0 in every other state.
REQ-018 In S_WAIT with imem_rvalid=1 SHALL capture instr<=imem_rdata and instr_pc<=pc, and go to S_HOLD; otherwise remain in S_WAIT indefinitely.
REQ-019 SHALL drive instr_valid=1 exactly while in S_HOLD.
REQ-020 In S_HOLD with stall=1 SHALL hold instr, instr_pc and pc unchanged and ignore branch_taken.
REQ-021 In S_HOLD with stall=0 SHALL load pc<=branch_taken ? {branch_target[31:2],2'b00} : pc+4, and go to S_FETCH.
REQ-022 Minimum fetch cadence SHALL be 3 cycles per instruction (request to valid latency 2 cycles with zero-wait memory).
REQ-023 SHALL ignore imem_rvalid in S_RESET, S_FETCH and S_HOLD; at most one request SHALL be outstanding.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 opcode SHALL be combinationally equal to instr[6:0] at all times.

Reset
REQ-026 While rst_n=0 SHALL force state=S_RESET, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_pc=0, instr_valid=0, imem_req=0, misalign_err=0.
REQ-027 Reset asserted mid-S_WAIT SHALL abandon the request; a late imem_rvalid after release SHALL be ignored until the next S_WAIT.

Configuration
REQ-028 With IFETCH_MISALIGN_CHK_EN defined, a redirect where branch_target[1:0]!=0 SHALL pulse misalign_err=1 for the cycle after the redirect; the target is still aligned per REQ-021.
REQ-029 Without IFETCH_MISALIGN_CHK_EN, misalign_err SHALL be tied 0 and no check logic SHALL be synthesised.

Structure
REQ-030 Shared package riscv_pkg SHALL hold the opcode constants (OP_RTYPE 0110011, OP_ITYPE 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011), the NOP constant, the fetch-state enum and the default RESET_PC.
REQ-031 Next-PC selection, alignment and the misalign flag SHALL live in one combinational sub-module, fetch_pc_gen.

Verification
REQ-032 Reset release, RESET_PC=0, zero-wait memory returning 0x00000033 -> imem_req at cycle 1 with addr 0; instr_valid at cycle 3 with instr_pc=0 and opcode=0110011.
REQ-033 Three sequential fetches, no stall -> imem_addr 0x0, 0x4, 0x8, with one request every 3 cycles.
REQ-034 stall=1 for 5 cycles in S_HOLD with branch_taken=1 -> instr, instr_pc and pc unchanged, no imem_req, branch ignored.
REQ-035 branch_taken=1, target 0x100, stall=0 -> next imem_addr=0x100; target 0x102 with macro -> addr 0x100 and a one-cycle misalign_err pulse.
REQ-036 pc=0xFFFFFFFC consumed -> next imem_addr=0x0; rst_n pulsed low during S_WAIT, then a stale rvalid -> ignored and fetch restarts at RESET_PC.
